// File: rtl/minicpu_multicycle.sv
// minicpu_multicycle: multi-cycle LA32 mini core that fetches, executes and retires
//   one instruction at a time (FETCH -> EXEC -> [MEM] -> WB, plus absorbing HALT).
// Ports: clk/reset (sync, active-high); inst_* fetch req/ack port; data_* load/store
//   req/ack port; debug_wb_* retire trace pulse; instret retire count; halted status.
// Latency: ALU/branch 3 cycles, ld.w/st.w 4 cycles with zero-wait memories, +1 per
//   ack wait cycle. Requests are held stable until ack; all outputs are 0 during reset.
module minicpu_multicycle #(
  parameter logic [31:0] RESET_PC        = 32'h1c000000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ack,
  input  logic [31:0] inst_rdata,
  output logic        data_req,
  output logic        data_we,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_ack,
  input  logic [31:0] data_rdata,
  output logic        debug_wb_valid,
  output logic [31:0] debug_wb_pc,
  output logic        debug_wb_we,
  output logic [4:0]  debug_wb_rnum,
  output logic [31:0] debug_wb_wdata,
  output logic [31:0] instret,
  output logic        halted
);

  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  state_t state, state_nxt;

  logic [31:0] pc, ir, instret_q;
  logic [31:0] gpr [32];
  // Values computed in EXEC and consumed by MEM/WB
  logic [31:0] res_q, npc_q, maddr_q, sdata_q;
  logic        gr_we_q, st_q;

  // ---------------- decode ----------------
  logic [5:0] op6;
  logic [3:0] op4;
  logic [1:0] op2;
  logic [4:0] op5, rd, rj, rk;
  assign op6 = ir[31:26];
  assign op4 = ir[25:22];
  assign op2 = ir[21:20];
  assign op5 = ir[19:15];
  assign rd  = ir[4:0];
  assign rj  = ir[9:5];
  assign rk  = ir[14:10];

  logic is_add, is_sub, is_addi, is_ld, is_st, is_lu12i, is_b, is_beq, is_bne, legal;
  assign is_add   = (op6 == 6'h00) && (op4 == 4'h0) && (op2 == 2'h1) && (op5 == 5'h00);
  assign is_sub   = (op6 == 6'h00) && (op4 == 4'h0) && (op2 == 2'h1) && (op5 == 5'h02);
  assign is_addi  = (op6 == 6'h00) && (op4 == 4'ha);
  assign is_ld    = (op6 == 6'h0a) && (op4 == 4'h2);
  assign is_st    = (op6 == 6'h0a) && (op4 == 4'h6);
  assign is_lu12i = (ir[31:25] == 7'b0001010);
  assign is_b     = (op6 == 6'h14);
  assign is_beq   = (op6 == 6'h16);
  assign is_bne   = (op6 == 6'h17);
  assign legal    = is_add | is_sub | is_addi | is_ld | is_st | is_lu12i |
                    is_b | is_beq | is_bne;

  // r0 is cleared at reset and never written, so it always reads 0
  logic [31:0] rj_val, rk_val, rd_val;
  assign rj_val = gpr[rj];
  assign rk_val = gpr[rk];
  assign rd_val = gpr[rd];

  logic [31:0] si12, ea, br_off, b_off, pc_seq;
  logic        misalign;
  assign si12     = {{20{ir[21]}}, ir[21:10]};
  assign ea       = rj_val + si12;
  assign misalign = (is_ld | is_st) && (ea[1:0] != 2'b00);
  assign br_off   = {{14{ir[25]}}, ir[25:10], 2'b00};
  assign b_off    = {{4{ir[9]}}, ir[9:0], ir[25:10], 2'b00};
  assign pc_seq   = pc + 32'd4;

  // ---------------- execute ----------------
  logic [31:0] ex_res, ex_npc;
  logic        ex_gr_we, br_taken;

  // Undecoded words fall through with no write and pc+4, i.e. a NOP when not halting
  always_comb begin
    ex_res   = 32'h0;
    ex_gr_we = 1'b0;
    if (is_add) begin
      ex_res   = rj_val + rk_val;
      ex_gr_we = 1'b1;
    end else if (is_sub) begin
      ex_res   = rj_val - rk_val;
      ex_gr_we = 1'b1;
    end else if (is_addi) begin
      ex_res   = rj_val + si12;
      ex_gr_we = 1'b1;
    end else if (is_lu12i) begin
      ex_res   = {ir[24:5], 12'h000};
      ex_gr_we = 1'b1;
    end else if (is_ld) begin
      ex_gr_we = 1'b1;          // result replaced by load data in MEM
    end else if (is_st) begin
      ex_res   = rd_val;
    end
  end

  assign br_taken = (is_beq && (rj_val == rd_val)) || (is_bne && (rj_val != rd_val));
  assign ex_npc   = is_b ? (pc + b_off) : (br_taken ? (pc + br_off) : pc_seq);

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // ---------------- next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: if (inst_ack) state_nxt = S_EXEC;
      S_EXEC: begin
        if (HALT_ON_ILLEGAL && (!legal || misalign)) state_nxt = S_HALT;
        else if (is_ld || is_st)                     state_nxt = S_MEM;
        else                                         state_nxt = S_WB;
      end
      S_MEM:   if (data_ack) state_nxt = S_WB;
      S_WB:    state_nxt = S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
  end

  // ---------------- outputs ----------------
  // Gated by reset so an in-flight request is abandoned as soon as reset is seen
  always_comb begin
    inst_req       = 1'b0;
    inst_addr      = 32'h0;
    data_req       = 1'b0;
    data_we        = 1'b0;
    data_addr      = 32'h0;
    data_wdata     = 32'h0;
    debug_wb_valid = 1'b0;
    debug_wb_pc    = 32'h0;
    debug_wb_we    = 1'b0;
    debug_wb_rnum  = 5'h0;
    debug_wb_wdata = 32'h0;
    instret        = 32'h0;
    halted         = 1'b0;
    if (!reset) begin
      inst_addr = pc;
      instret   = instret_q;
      case (state)
        S_FETCH: inst_req = 1'b1;
        S_MEM: begin
          data_req   = 1'b1;
          data_we    = st_q;
          data_addr  = maddr_q;
          data_wdata = sdata_q;
        end
        S_WB: begin
          debug_wb_valid = 1'b1;
          debug_wb_pc    = pc;
          debug_wb_we    = gr_we_q && (rd != 5'd0);
          debug_wb_rnum  = rd;
          debug_wb_wdata = res_q;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      ir        <= 32'h0;
      instret_q <= 32'h0;
      res_q     <= 32'h0;
      npc_q     <= 32'h0;
      maddr_q   <= 32'h0;
      sdata_q   <= 32'h0;
      gr_we_q   <= 1'b0;
      st_q      <= 1'b0;
    end else begin
      case (state)
        S_FETCH: if (inst_ack) ir <= inst_rdata;
        S_EXEC: begin
          res_q   <= ex_res;
          npc_q   <= ex_npc;
          // Low bits forced to 0: only reachable misaligned when not halting on it
          maddr_q <= {ea[31:2], 2'b00};
          sdata_q <= rd_val;
          gr_we_q <= ex_gr_we;
          st_q    <= is_st;
        end
        S_MEM: if (data_ack && !st_q) res_q <= data_rdata;
        S_WB: begin
          instret_q <= instret_q + 32'd1;
          pc        <= npc_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) gpr[i] <= 32'h0;
    end else if ((state == S_WB) && gr_we_q && (rd != 5'd0)) begin
      gpr[rd] <= res_q;
    end
  end

endmodule
